fetch_stage: RTL and testbench

- Fetch (FE) stage of the LC-3b 5-stage pipeline; sits directly upstream of the decode stage and drives its de_npc / de_ir / de_v inputs.
- Owns the PC and the DE pipeline latches.
- Issues word fetches to the instruction memory over a req/rdy handshake.
- Honours dependency, memory and branch stalls, and the MEM-stage PC redirect.
- Buffers one fetched word when DE cannot accept it.

---
 rtl/lc3b_pipe_pkg.sv | 16 +
 rtl/fetch_imem_if.sv | 90 +++++++++
 rtl/fetch_stage.sv | 122 ++++++++++++
 tb/tb_fetch_stage.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_pipe_pkg.sv
// rtl/lc3b_pipe_pkg.sv - Shared LC-3b pipeline encodings: PC mux selects, FE states, reset PC
package lc3b_pipe_pkg;

    localparam logic [1:0] PCMUX_NPC    = 2'd0;
    localparam logic [1:0] PCMUX_TARGET = 2'd1;
    localparam logic [1:0] PCMUX_TRAP   = 2'd2;

    typedef enum logic [1:0] {
        FE_BUSY  = 2'd0,
        FE_HOLD  = 2'd1,
        FE_FLUSH = 2'd2
    } fe_state_e;

    localparam logic [15:0] PC_RESET_DEFAULT = 16'h3000;

endpackage

// File: rtl/fetch_imem_if.sv
// rtl/fetch_imem_if.sv - Instruction memory req/rdy FSM with request address latch and one-word hold buffer
module fetch_imem_if
    import lc3b_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_i,
    input  logic        ld_de_i,
    input  logic        br_stall_i,
    input  logic        redirect_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_rdy_i,
    input  logic [15:0] imem_rdata_i,
    output logic        deliver_o,
    output logic [15:0] deliver_word_o
);

    fe_state_e   state_q;
    logic        start_q;
    logic        out_q;
    logic [15:0] req_addr_q;
    logic [15:0] buf_q;
    logic        in_busy;
    logic        in_hold;
    logic        in_flush;
    logic        pending;
    logic        rdy;

    assign in_busy  = (state_q == FE_BUSY);
    assign in_hold  = (state_q == FE_HOLD);
    assign in_flush = (state_q == FE_FLUSH);

    // start_q keeps the bus quiet for one cycle so a response to a request
    // abandoned by reset cannot be mistaken for the first fetch.
    assign imem_req_o  = (in_busy & ~br_stall_i & ~start_q) | in_flush;
    assign imem_addr_o = in_flush ? req_addr_q : pc_i;

    // out_q covers a request whose req was dropped by a branch stall after issue.
    assign pending = (in_busy & (imem_req_o | out_q)) | in_flush;
    assign rdy     = imem_rdy_i & pending;

    assign deliver_o      = ~redirect_i & ld_de_i & ~br_stall_i & ((in_busy & rdy) | in_hold);
    assign deliver_word_o = in_hold ? buf_q : imem_rdata_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FE_BUSY;
            start_q    <= 1'b1;
            out_q      <= 1'b0;
            req_addr_q <= '0;
            buf_q      <= '0;
        end else begin
            start_q <= 1'b0;
            if (in_busy && imem_req_o) begin
                req_addr_q <= pc_i;
            end
            if (redirect_i) begin
                state_q <= (pending && !imem_rdy_i) ? FE_FLUSH : FE_BUSY;
                out_q   <= 1'b0;
            end else begin
                case (state_q)
                    FE_BUSY: begin
                        if (rdy) begin
                            out_q <= 1'b0;
                            if (!br_stall_i && !ld_de_i) begin
                                buf_q   <= imem_rdata_i;
                                state_q <= FE_HOLD;
                            end
                        end else if (imem_req_o) begin
                            out_q <= 1'b1;
                        end
                    end
                    FE_HOLD: begin
                        if (ld_de_i || br_stall_i) begin
                            state_q <= FE_BUSY;
                        end
                    end
                    FE_FLUSH: begin
                        if (imem_rdy_i) begin
                            state_q <= FE_BUSY;
                        end
                    end
                    default: state_q <= FE_BUSY;
                endcase
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LC-3b fetch stage: PC, next-PC mux and DE latches; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
    import lc3b_pipe_pkg::*;
#(
    parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_rdata,
    input  logic        dep_stall,
    input  logic        mem_stall,
    input  logic        v_de_br_stall,
    input  logic        v_agex_br_stall,
    input  logic        v_mem_br_stall,
    input  logic [1:0]  mem_pcmux,
    input  logic [15:0] target_pc,
    input  logic [15:0] trap_pc,
    output logic [15:0] de_npc,
    output logic [15:0] de_ir,
    output logic        de_v
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    logic        ld_de;
    logic        br_stall;
    logic        redirect;
    logic        deliver;
    logic [15:0] deliver_word;
    logic [15:0] pc_q, pc_d;
    logic [15:0] pc_plus2;
    logic [15:0] de_npc_q, de_npc_d;
    logic [15:0] de_ir_q, de_ir_d;
    logic        de_v_q, de_v_d;

    assign ld_de    = ~dep_stall & ~mem_stall;
    assign br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
    assign redirect = (mem_pcmux == PCMUX_TARGET) | (mem_pcmux == PCMUX_TRAP);
    assign pc_plus2 = pc_q + 16'd2;

    fetch_imem_if u_imem_if (
        .clk            (clk),
        .reset          (reset),
        .pc_i           (pc_q),
        .ld_de_i        (ld_de),
        .br_stall_i     (br_stall),
        .redirect_i     (redirect),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_rdy_i     (imem_rdy),
        .imem_rdata_i   (imem_rdata),
        .deliver_o      (deliver),
        .deliver_word_o (deliver_word)
    );

    always_comb begin
        pc_d     = pc_q;
        de_npc_d = de_npc_q;
        de_ir_d  = de_ir_q;
        de_v_d   = de_v_q;
        // deliver is already suppressed by redirect, so the two never collide
        if (redirect) begin
            pc_d = (mem_pcmux == PCMUX_TRAP) ? trap_pc : target_pc;
        end else if (deliver) begin
            pc_d = pc_plus2;
        end
        if (ld_de) begin
            de_v_d = deliver;
            if (deliver) begin
                de_npc_d = pc_plus2;
                de_ir_d  = deliver_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            de_npc_q <= '0;
            de_ir_q  <= '0;
            de_v_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            de_npc_q <= de_npc_d;
            de_ir_q  <= de_ir_d;
            de_v_q   <= de_v_d;
        end
    end

    assign de_npc = de_npc_q;
    assign de_ir  = de_ir_q;
    assign de_v   = de_v_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (deliver) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (ld_de && !deliver) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - Self-checking bench for fetch_stage: directed table, latency/flush/hold/reset sequences, random scoreboard
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_rdata;
    logic        dep_stall = 1'b0;
    logic        mem_stall = 1'b0;
    logic        v_de_br_stall = 1'b0;
    logic        v_agex_br_stall = 1'b0;
    logic        v_mem_br_stall = 1'b0;
    logic [1:0]  mem_pcmux = 2'd0;
    logic [15:0] target_pc = 16'h0;
    logic [15:0] trap_pc = 16'h0;
    logic [15:0] de_npc;
    logic [15:0] de_ir;
    logic        de_v;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rdy        (imem_rdy),
        .imem_rdata      (imem_rdata),
        .dep_stall       (dep_stall),
        .mem_stall       (mem_stall),
        .v_de_br_stall   (v_de_br_stall),
        .v_agex_br_stall (v_agex_br_stall),
        .v_mem_br_stall  (v_mem_br_stall),
        .mem_pcmux       (mem_pcmux),
        .target_pc       (target_pc),
        .trap_pc         (trap_pc),
        .de_npc          (de_npc),
        .de_ir           (de_ir),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt),
`endif
        .de_v            (de_v)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Memory model: a request occupies lat cycles, lat==1 answers in the issue cycle.
    int          lat = 1;
    logic        stale = 1'b0;
    logic        mbusy = 1'b0;
    int          mcnt = 0;
    logic [15:0] maddr = 16'h0;

    function automatic logic [15:0] mword(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mbusy <= 1'b0;
        end else if (mbusy) begin
            if (mcnt == 0) mbusy <= 1'b0;
            else mcnt <= mcnt - 1;
        end else if (imem_req && lat > 1) begin
            mbusy <= 1'b1;
            mcnt  <= lat - 2;
            maddr <= imem_addr;
        end
    end

    assign imem_rdy   = stale | (mbusy && mcnt == 0) | (!mbusy && imem_req && lat == 1);
    assign imem_rdata = stale ? 16'hDEAD : mword(mbusy ? maddr : imem_addr);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Target and trap carry different values so a swapped select is visible.
    task automatic set_in(input logic ds, input logic ms, input logic br,
                          input logic [1:0] pm, input logic [15:0] tgt);
        dep_stall       = ds;
        mem_stall       = ms;
        v_de_br_stall   = br;
        v_agex_br_stall = 1'b0;
        v_mem_br_stall  = 1'b0;
        mem_pcmux       = pm;
        target_pc       = (pm == 2'd2) ? ~tgt : tgt;
        trap_pc         = (pm == 2'd2) ? tgt : ~tgt;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        cyc();
        @(negedge clk);
        chk("rst_req", 16'(imem_req), 16'h0);
        cyc();
        reset = 1'b0;
    endtask

    typedef struct {
        logic        ds, ms, br;
        logic [1:0]  pm;
        logic [15:0] tgt;
        logic        req;
        logic [15:0] addr;
        logic        v;
        logic [15:0] npc;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic ds, input logic ms, input logic br,
                                input logic [1:0] pm, input logic [15:0] tgt,
                                input logic req, input logic [15:0] addr,
                                input logic v, input logic [15:0] npc);
        vec_t t;
        t.ds = ds; t.ms = ms; t.br = br; t.pm = pm; t.tgt = tgt;
        t.req = req; t.addr = addr; t.v = v; t.npc = npc;
        return t;
    endfunction

    logic [15:0] exp_pc, prev_tgt, pnpc, pir;
    logic        prev_ld, prev_br, prev_redir, pv, stuck;
    int          gap, deliveries, r;
    logic [1:0]  pm;
    logic [15:0] tgt;

    initial begin
        tbl[0]  = mk(0,0,0,2'd0,16'h0000, 0,16'h0000, 0,16'h0000);
        tbl[1]  = mk(0,0,0,2'd0,16'h0000, 1,16'h3000, 0,16'h0000);
        tbl[2]  = mk(0,0,0,2'd0,16'h0000, 1,16'h3002, 1,16'h3002);
        tbl[3]  = mk(0,0,0,2'd0,16'h0000, 1,16'h3004, 1,16'h3004);
        tbl[4]  = mk(1,0,0,2'd0,16'h0000, 1,16'h3006, 1,16'h3006);
        tbl[5]  = mk(1,0,0,2'd0,16'h0000, 0,16'h0000, 1,16'h3006);
        tbl[6]  = mk(0,0,0,2'd0,16'h0000, 0,16'h0000, 1,16'h3006);
        tbl[7]  = mk(0,0,0,2'd0,16'h0000, 1,16'h3008, 1,16'h3008);
        tbl[8]  = mk(0,0,1,2'd0,16'h0000, 0,16'h0000, 1,16'h300A);
        tbl[9]  = mk(0,0,1,2'd0,16'h0000, 0,16'h0000, 0,16'h300A);
        tbl[10] = mk(0,0,1,2'd0,16'h0000, 0,16'h0000, 0,16'h300A);
        tbl[11] = mk(0,0,1,2'd0,16'h0000, 0,16'h0000, 0,16'h300A);
        tbl[12] = mk(0,0,0,2'd1,16'h4000, 1,16'h300A, 0,16'h300A);
        tbl[13] = mk(0,0,0,2'd0,16'h0000, 1,16'h4000, 0,16'h300A);
        tbl[14] = mk(0,0,0,2'd0,16'h0000, 1,16'h4002, 1,16'h4002);
        tbl[15] = mk(0,1,0,2'd2,16'h0200, 1,16'h4004, 1,16'h4004);
        tbl[16] = mk(0,0,0,2'd0,16'h0000, 1,16'h0200, 1,16'h4004);
        tbl[17] = mk(0,0,0,2'd0,16'h0000, 1,16'h0202, 1,16'h0202);
        tbl[18] = mk(0,0,0,2'd3,16'h5000, 1,16'h0204, 1,16'h0204);
        tbl[19] = mk(0,0,0,2'd0,16'h0000, 1,16'h0206, 1,16'h0206);
        tbl[20] = mk(0,0,0,2'd1,16'hFFFE, 1,16'h0208, 1,16'h0208);
        tbl[21] = mk(0,0,0,2'd0,16'h0000, 1,16'hFFFE, 0,16'h0208);
        tbl[22] = mk(0,0,0,2'd0,16'h0000, 1,16'h0000, 1,16'h0000);
        tbl[23] = mk(0,0,0,2'd0,16'h0000, 1,16'h0002, 1,16'h0002);

        lat = 1;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            set_in(tbl[i].ds, tbl[i].ms, tbl[i].br, tbl[i].pm, tbl[i].tgt);
            @(negedge clk);
            chk("tbl_req", 16'(imem_req), 16'(tbl[i].req));
            if (tbl[i].req) chk("tbl_addr", imem_addr, tbl[i].addr);
            chk("tbl_de_v", 16'(de_v), 16'(tbl[i].v));
            chk("tbl_de_npc", de_npc, tbl[i].npc);
            if (tbl[i].v) chk("tbl_de_ir", de_ir, mword(tbl[i].npc - 16'd2));
            else if (i == 0) chk("rst_de_ir", de_ir, 16'h0);
            cyc();
        end

        // 3-cycle memory: steady stream, trap redirect over pending 3010, then hold buffer
        lat = 3;
        do_reset();
        for (int k = 0; k < 37; k++) begin
            set_in(k == 33 || k == 34, 1'b0, 1'b0, (k == 26) ? 2'd2 : 2'd0, 16'h0200);
            @(negedge clk);
            if (k >= 2 && k <= 25) begin
                chk("lat3_de_v", 16'(de_v), 16'((k - 1) % 3 == 0));
                if ((k - 1) % 3 == 0)
                    chk("lat3_de_npc", de_npc, 16'h3000 + 16'(2 * ((k - 1) / 3)));
            end
            if (k == 25 || k == 27) begin
                chk("lat3_req_3010", 16'(imem_req), 16'h1);
                chk("lat3_addr_3010", imem_addr, 16'h3010);
            end
            if (k >= 26 && k <= 30) chk("flush_de_v", 16'(de_v), 16'h0);
            if (k == 28) begin
                chk("trap_req", 16'(imem_req), 16'h1);
                chk("trap_addr", imem_addr, 16'h0200);
            end
            if (k == 31) begin
                chk("trap_de_v", 16'(de_v), 16'h1);
                chk("trap_de_npc", de_npc, 16'h0202);
                chk("trap_de_ir", de_ir, mword(16'h0200));
            end
            if (k == 34 || k == 35) chk("hold_no_req", 16'(imem_req), 16'h0);
            if (k == 36) begin
                chk("hold_de_v", 16'(de_v), 16'h1);
                chk("hold_de_npc", de_npc, 16'h0204);
                chk("hold_de_ir", de_ir, mword(16'h0202));
                chk("hold_next_addr", imem_addr, 16'h0204);
            end
            cyc();
        end

        // Reset mid-request, stale response lands in the first post-reset cycle
        reset = 1'b1;
        cyc();
        @(negedge clk);
        chk("midrst_req", 16'(imem_req), 16'h0);
        chk("midrst_de_v", 16'(de_v), 16'h0);
        chk("midrst_de_npc", de_npc, 16'h0);
        cyc();
        reset = 1'b0;
        stale = 1'b1;
        @(negedge clk);
        chk("post_rst_req0", 16'(imem_req), 16'h0);
        cyc();
        stale = 1'b0;
        @(negedge clk);
        chk("stale_ignored_de_v", 16'(de_v), 16'h0);
        chk("post_rst_req1", 16'(imem_req), 16'h1);
        chk("post_rst_addr", imem_addr, 16'h3000);
        cyc();

        // Random stalls/redirects against a program-order scoreboard
        do_reset();
        exp_pc = 16'h3000;
        gap = 0;
        deliveries = 0;
        stuck = 1'b0;
        prev_ld = 1'b0; prev_br = 1'b0; prev_redir = 1'b0; prev_tgt = 16'h0;
        pv = 1'b0; pnpc = 16'h0; pir = 16'h0;
        for (int p = 0; p < 4 && !stuck; p++) begin
            lat = (p == 0) ? 1 : (p == 1) ? 3 : (p == 2) ? 2 : 4;
            for (int n = 0; n < 500; n++) begin
                r = $urandom_range(0, 99);
                pm = (r < 2) ? 2'd1 : (r < 4) ? 2'd2 : (r < 6) ? 2'd3 : 2'd0;
                tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFC : (16'($urandom) & 16'hFFFE);
                set_in($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                       $urandom_range(0, 15) == 0, pm, tgt);
                v_agex_br_stall = ($urandom_range(0, 15) == 0);
                v_mem_br_stall  = ($urandom_range(0, 15) == 0);
                @(negedge clk);
                if (p > 0 || n > 0) begin
                    if (!prev_ld) begin
                        chk("rnd_hold_v", 16'(de_v), 16'(pv));
                        chk("rnd_hold_npc", de_npc, pnpc);
                        chk("rnd_hold_ir", de_ir, pir);
                    end else if (prev_redir || prev_br) begin
                        chk("rnd_no_deliver", 16'(de_v), 16'h0);
                    end else if (de_v) begin
                        chk("rnd_npc", de_npc, exp_pc + 16'd2);
                        chk("rnd_ir", de_ir, mword(exp_pc));
                    end else begin
                        chk("rnd_bubble_npc", de_npc, pnpc);
                    end
                    if (prev_ld && de_v) begin
                        exp_pc = exp_pc + 16'd2;
                        gap = 0;
                        deliveries++;
                    end else begin
                        gap++;
                    end
                    if (prev_redir) exp_pc = prev_tgt;
                end
                if (mbusy && imem_req) chk("rnd_addr_stable", imem_addr, maddr);
                chk("rnd_no_issue_in_br",
                    16'((v_de_br_stall | v_agex_br_stall | v_mem_br_stall) && imem_req && !mbusy), 16'h0);
                if (gap > 300) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_progress: no delivery for %0d cycles, limit 300", gap);
                    stuck = 1'b1;
                    break;
                end
                prev_ld    = ~(dep_stall | mem_stall);
                prev_br    = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
                prev_redir = (mem_pcmux == 2'd1) || (mem_pcmux == 2'd2);
                prev_tgt   = (mem_pcmux == 2'd2) ? trap_pc : target_pc;
                pv   = de_v;
                pnpc = de_npc;
                pir  = de_ir;
                cyc();
            end
        end
        chk("rnd_deliveries_min", 16'(deliveries > 100), 16'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
